// File: rtl/mismatch_monitor_if.sv
// Purpose: bundles the monitor's control inputs and status outputs.
// Latency: none (wiring only).
// Backpressure: none; the clear request/acknowledge pair is the only handshake.
interface mismatch_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             p;
  logic             clr_req;
  logic             clr_ack;
  logic             mismatch;
  logic             evt_pulse;
  logic             alarm;
  logic [CNT_W-1:0] event_cnt;

  // Supervisor side: drives enable, flag and clear request.
  modport master (
    output en, p, clr_req,
    input  clr_ack, mismatch, evt_pulse, alarm, event_cnt
  );

  // Monitor side.
  modport slave (
    input  en, p, clr_req,
    output clr_ack, mismatch, evt_pulse, alarm, event_cnt
  );
endinterface

// File: rtl/mismatch_monitor.sv
// Purpose: glitch-filters the active-low mismatch flag, counts confirmed events, sticky alarm, clear handshake.
// Latency: mismatch/evt_pulse/alarm change FILT_LEN-1 edges after the first qualifying sample; clear acts on the edge clr_req is first seen high.
// Backpressure: none; clr_ack is a one-cycle pulse per clr_req rising edge, holding clr_req high does nothing more.
module mismatch_monitor #(
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 8
) (
  input logic          clk,
  input logic          rst_n,
  mismatch_monitor_if.slave mon
);

  typedef enum logic [1:0] {IDLE, FILT, ACTIVE, RECOV} state_t;

  // Terminal run count: the FILT_LEN-th consecutive sample arrives when the counter already holds FILT_LEN-1.
  localparam logic [3:0]       RUN_LAST = 4'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_run;
  logic [3:0]       w_run_nxt;
  logic             r_mismatch;
  logic             w_mismatch_nxt;
  logic             w_evt;
  logic             r_evt_pulse;
  logic             r_alarm;
  logic             w_alarm_nxt;
  logic [CNT_W-1:0] r_event_cnt;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_clr_req_q;
  logic             w_clr_rise;
  logic             r_clr_ack;

  // Filter FSM state, run counter and filtered level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_run      <= 4'd0;
      r_mismatch <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_run      <= w_run_nxt;
      r_mismatch <= w_mismatch_nxt;
    end
  end

  // Next-state logic: a run of FILT_LEN identical samples is needed to enter or leave the mismatch condition.
  always_comb begin
    w_state_nxt    = r_state;
    w_run_nxt      = r_run;
    w_mismatch_nxt = r_mismatch;
    w_evt          = 1'b0;
    if (!mon.en) begin
      w_state_nxt    = IDLE;
      w_run_nxt      = 4'd0;
      w_mismatch_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!mon.p) begin
            w_run_nxt   = 4'd1;
            w_state_nxt = FILT;
          end
        end
        FILT: begin
          if (mon.p) begin
            w_run_nxt   = 4'd0;
            w_state_nxt = IDLE;
          end else if (r_run == RUN_LAST) begin
            w_run_nxt      = 4'd0;
            w_state_nxt    = ACTIVE;
            w_mismatch_nxt = 1'b1;
            w_evt          = 1'b1;
          end else begin
            w_run_nxt = r_run + 4'd1;
          end
        end
        ACTIVE: begin
          if (mon.p) begin
            w_run_nxt   = 4'd1;
            w_state_nxt = RECOV;
          end
        end
        RECOV: begin
          if (!mon.p) begin
            w_run_nxt   = 4'd0;
            w_state_nxt = ACTIVE;
          end else if (r_run == RUN_LAST) begin
            w_run_nxt      = 4'd0;
            w_state_nxt    = IDLE;
            w_mismatch_nxt = 1'b0;
          end else begin
            w_run_nxt = r_run + 4'd1;
          end
        end
        default: begin
          w_run_nxt   = 4'd0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Clear edge detect; alarm/count update with the clear applied before a same-cycle event.
  always_comb begin
    w_clr_rise  = mon.clr_req & ~r_clr_req_q;
    w_cnt_base  = w_clr_rise ? '0 : r_event_cnt;
    w_cnt_nxt   = w_cnt_base;
    w_alarm_nxt = w_clr_rise ? 1'b0 : r_alarm;
    if (w_evt) begin
      w_alarm_nxt = 1'b1;
      if (w_cnt_base != CNT_MAX) begin
        w_cnt_nxt = w_cnt_base + CNT_ONE;
      end
    end
  end

  // Event, alarm, counter and handshake registers; alarm/count survive en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_pulse <= 1'b0;
      r_alarm     <= 1'b0;
      r_event_cnt <= '0;
      r_clr_req_q <= 1'b0;
      r_clr_ack   <= 1'b0;
    end else begin
      r_evt_pulse <= w_evt;
      r_alarm     <= w_alarm_nxt;
      r_event_cnt <= w_cnt_nxt;
      r_clr_req_q <= mon.clr_req;
      r_clr_ack   <= w_clr_rise;
    end
  end

  assign mon.mismatch  = r_mismatch;
  assign mon.evt_pulse = r_evt_pulse;
  assign mon.alarm     = r_alarm;
  assign mon.event_cnt = r_event_cnt;
  assign mon.clr_ack   = r_clr_ack;

endmodule

// File: tb/tb_mismatch_monitor.sv
// Purpose: directed table-driven check of mismatch_monitor (FILT_LEN=4, CNT_W=2).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_mismatch_monitor;

  logic clk;
  logic rst_n;

  mismatch_monitor_if #(.CNT_W(2)) bus ();

  mismatch_monitor #(.FILT_LEN(4), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record: inputs applied before an edge, outputs expected just after it.
  typedef struct {
    logic       en;
    logic       p;
    logic       clr;
    logic [5:0] exp; // {mismatch, evt_pulse, alarm, clr_ack, event_cnt[1:0]}
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;
  int   pulses_seen;
  int   pulses_exp;

  function automatic void add(input logic en, input logic p, input logic clr,
                              input logic mm, input logic evt, input logic al,
                              input logic ack, input int cnt);
    vec_t v;
    v.en  = en;
    v.p   = p;
    v.clr = clr;
    v.exp = {mm, evt, al, ack, 2'(cnt)};
    vecs.push_back(v);
  endfunction

  // Four low samples from IDLE: three quiet rows, then the event row.
  function automatic void add_event(input logic al0, input int c0, input int c1);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, al0, 1'b0, c0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, c1);
  endfunction

  // Four high samples from ACTIVE: mismatch drops on the fourth.
  function automatic void add_exit(input int c);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, c);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c);
  endfunction

  function automatic logic [5:0] obs();
    return {bus.mismatch, bus.evt_pulse, bus.alarm, bus.clr_ack, bus.event_cnt};
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {mm,evt,alarm,ack,cnt}=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input string name, input vec_t v);
    bus.en      = v.en;
    bus.p       = v.p;
    bus.clr_req = v.clr;
    step();
    if (bus.evt_pulse === 1'b1) pulses_seen++;
    if (v.exp[4]) pulses_exp++;
    chk(name, obs(), v.exp);
  endtask

  initial begin
    vec_t hv;
    checks      = 0;
    errors      = 0;
    pulses_seen = 0;
    pulses_exp  = 0;

    // Entry straight after reset, then the recovery bounce.
    add_event(1'b0, 0, 1);
    add(1, 0, 0, 1, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 1, 0, 1, 0, 1);
    add(1, 0, 0, 1, 0, 1, 0, 1);
    add_exit(1);
    // Glitch rejection: 3 low, 5 high, 3 low, then back high.
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 1, 0, 1);
    add(1, 1, 0, 0, 0, 1, 0, 1);
    // Bring the count to 3, then the clear handshake held for 5 cycles and re-armed.
    add_event(1'b1, 1, 2);
    add_exit(2);
    add_event(1'b1, 2, 3);
    add_exit(3);
    add(1, 1, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    // Simultaneous event and clear with count already at 1.
    add_event(1'b0, 0, 1);
    add_exit(1);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 1, 0, 1);
    add(1, 0, 1, 1, 1, 1, 1, 1);
    add(1, 0, 1, 1, 0, 1, 0, 1);
    add_exit(1);
    add(1, 1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    // Saturation: five events into a 2-bit counter.
    for (int e = 1; e <= 5; e++) begin
      add_event(e > 1, (e - 1 > 3) ? 3 : e - 1, (e > 3) ? 3 : e);
      if (e < 5) add_exit((e > 3) ? 3 : e);
    end
    add(1, 0, 0, 1, 0, 1, 0, 3);
    // Disable in ACTIVE: mismatch drops, alarm/count hold; re-enable with p low needs a full run.
    add(0, 0, 0, 0, 0, 1, 0, 3);
    add(0, 0, 0, 0, 0, 1, 0, 3);
    add_event(1'b1, 3, 3);
    // Clear works while disabled; no filtering while disabled.
    add(0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0);
    add_event(1'b0, 0, 1);
    add_exit(1);
    add(1, 0, 0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 1, 0, 1);

    // Held reset with p low: nothing may move.
    rst_n       = 1'b0;
    bus.en      = 1'b1;
    bus.p       = 1'b0;
    bus.clr_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("reset_hold_%0d", i), obs(), 6'b0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec_%0d", i), vecs[i]);

    // Reset mid-run (FILT, two lows seen, alarm set): asynchronous clear, partial run discarded.
    rst_n = 1'b0;
    #2;
    chk("async_reset", obs(), 6'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("reset_mid_%0d", i), obs(), 6'b0);
    end
    rst_n = 1'b1;
    hv.en  = 1'b1;
    hv.p   = 1'b0;
    hv.clr = 1'b0;
    hv.exp = 6'b000000;
    for (int i = 0; i < 3; i++) apply($sformatf("post_reset_low_%0d", i), hv);
    hv.exp = 6'b111001;
    apply("post_reset_event", hv);

    checks++;
    if (pulses_seen != pulses_exp) begin
      errors++;
      $display("FAIL evt_pulse_total: got %0d pulses, expected %0d", pulses_seen, pulses_exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
